// File: rtl/float_to_twos_decoder.sv
// float_to_twos_decoder
// Rebuilds a two's-complement value D = (-1)^S * F * 2^E from the 8-bit float
// code produced by the linear-to-float encoder. The magnitude is formed by a
// one-bit-per-cycle shifter, then negated when S is set. Valid/ready on both
// sides, one operation in flight at a time.
module float_to_twos_decoder #(
  parameter int EXP_W = 3,
  parameter int SIG_W = 4,
  parameter int OUT_W = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    S,
  input  logic [EXP_W-1:0]        E,
  input  logic [SIG_W-1:0]        F,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] D
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [OUT_W-1:0]   acc;
  logic [EXP_W-1:0]   cnt;
  logic               sgn;
  logic               accept;
  logic               shift_last;

  // Two's-complement negation of the magnitude; S=1 with F=0 folds to 0.
  function automatic logic signed [OUT_W-1:0] apply_sign(
    input logic             neg,
    input logic [OUT_W-1:0] mag
  );
    logic [OUT_W-1:0] res;
    res = neg ? (~mag + OUT_W'(1)) : mag;
    return signed'(res);
  endfunction

  assign accept     = in_valid && in_ready;
  assign shift_last = (cnt == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)     state_nxt = SHIFT;
      SHIFT:   if (shift_last) state_nxt = DONE;
      DONE:    if (out_ready)  state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Handshake outputs; in_ready is masked while reset is held.
  always_comb begin
    in_ready  = (state == IDLE) && !reset;
    out_valid = (state == DONE);
  end

  // Datapath: capture on accept, shift once per cycle, write D on the last step.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      cnt <= '0;
      sgn <= 1'b0;
      D   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc <= OUT_W'(F);
            cnt <= E;
            sgn <= S;
          end
        end
        SHIFT: begin
          if (!shift_last) begin
            acc <= acc << 1;
            cnt <= cnt - EXP_W'(1);
          end else begin
            D <= apply_sign(sgn, acc);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float_to_twos_decoder.sv
// Bench for float_to_twos_decoder: directed cases plus a randomized-stall sweep
// of all 256 codes against an arithmetic model (-1)^S * F * 2^E.
module tb_float_to_twos_decoder;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        S;
  logic [2:0]  E;
  logic [3:0]  F;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] D;

  int checks   = 0;
  int failures = 0;

  float_to_twos_decoder #(
    .EXP_W(3),
    .SIG_W(4),
    .OUT_W(12)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .S        (S),
    .E        (E),
    .F        (F),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .D        (D)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [11:0] model(input logic s, input logic [2:0] e, input logic [3:0] f);
    int mag;
    int val;
    mag = int'(f) * (1 << int'(e));
    val = s ? -mag : mag;
    return 12'(val);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one code, measure latency, stall the result for 'stall' cycles while
  // presenting a competing input, then release it. Called at posedge+1.
  task automatic do_op(input logic s, input logic [2:0] e, input logic [3:0] f,
                       input int stall, input string tag);
    int          lat;
    logic [11:0] exp_d;
    exp_d = model(s, e, f);
    chk({tag, "_in_ready"}, in_ready, 1);
    in_valid  = 1'b1;
    S         = s;
    E         = e;
    F         = f;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    S = 1'($urandom);
    E = 3'($urandom);
    F = 4'($urandom);
    lat = 0;
    while (!out_valid && lat < 12) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, lat, int'(e) + 1);
    chk({tag, "_D"}, D, exp_d);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      S = 1'b0;
      E = 3'd1;
      F = 4'b0011;
      step();
      chk({tag, "_stall_valid"}, out_valid, 1);
      chk({tag, "_stall_ready"}, in_ready, 0);
      chk({tag, "_stall_D"}, D, exp_d);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_post_valid"}, out_valid, 0);
    chk({tag, "_post_ready"}, in_ready, 1);
    chk({tag, "_post_D"}, D, exp_d);
  endtask

  initial begin
    logic [7:0] code;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    S = 1'b0;
    E = '0;
    F = '0;
    repeat (3) step();
    chk("rst_D", D, 12'h000);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    reset = 1'b0;
    #1;
    chk("rst_release_ready", in_ready, 1);
    step();

    do_op(1'b0, 3'd0, 4'b0001, 0, "min");
    do_op(1'b1, 3'd7, 4'b1111, 0, "max_neg");
    do_op(1'b0, 3'd3, 4'b0101, 0, "forty");
    do_op(1'b1, 3'd5, 4'b1010, 5, "backpressure");
    do_op(1'b0, 3'd1, 4'b0011, 0, "after_stall");
    do_op(1'b1, 3'd5, 4'b0000, 1, "neg_zero");

    // Reset in the middle of a shift sequence.
    in_valid = 1'b1;
    S = 1'b0;
    E = 3'd6;
    F = 4'b1010;
    step();
    in_valid = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    #1;
    chk("midrst_in_ready_low", in_ready, 0);
    step();
    reset = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_D", D, 12'h000);
    chk("midrst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("midrst_no_result", out_valid, 0);
    end
    out_ready = 1'b0;
    do_op(1'b1, 3'd2, 4'b0011, 0, "after_rst");

    // Full sweep with random stalls and idle gaps.
    for (int c = 0; c < 256; c++) begin
      code = 8'(c);
      repeat ($urandom_range(0, 1)) step();
      do_op(code[7], code[6:4], code[3:0], int'($urandom_range(0, 3)), "sweep");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
